dram_req_arbiter: RTL
=====================

DRAM_REQ_ARBITER -- requirements
Module: dram_req_arbiter

Interface
REQ-001 Parameter ADDR_W, 27, DRAM address width.
REQ-002 Parameter DATA_W, 128, DRAM data word width.
REQ-003 Parameter WR_BURST_MAX, 16, max consecutive writes accepted while a read waits.
REQ-004 Parameter RD_BURST_MAX, 8, max consecutive reads accepted while a write waits.
REQ-005 clk  in  1  system clock; single clock domain, all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 cap_write_req  in  1  capture-side write request.
REQ-008 cap_wr_adx  in  ADDR_W  capture write address.
REQ-009 cap_wr_data  in  DATA_W  capture write data.
REQ-010 cap_write_allowed  out  1  capture write accepted this cycle when high with cap_write_req.
REQ-011 rb_read_req  in  1  readback-side read request.
REQ-012 rb_rd_adx  in  ADDR_W  readback read address.
REQ-013 rb_read_allowed  out  1  readback read accepted this cycle when high with rb_read_req.
REQ-014 mem_write_req / mem_wr_adx / mem_wr_data  out  1/ADDR_W/DATA_W  to memory interface.
REQ-015 mem_write_allowed, mem_writes_pending  in  1 each  from memory interface.
REQ-016 mem_read_req / mem_rd_adx  out  1/ADDR_W  to memory interface.
REQ-017 mem_read_allowed, mem_reads_pending  in  1 each  from memory interface.
REQ-018 mem_mode  out  1  0 = write direction, 1 = read direction; registered.
REQ-019 arb_state  out  3  current FSM state encoding, for debug.

Function
REQ-020 FSM states SHALL be IDLE, WRITE, DRAIN_W, READ, DRAIN_R; state register only.
REQ-021 Accept = req && allowed in same cycle; exactly one transfer per accept.
REQ-022 In WRITE: mem_write_req = cap_write_req, cap_write_allowed = mem_write_allowed, combinational; else both 0.
REQ-023 In READ: mem_read_req = rb_read_req, rb_read_allowed = mem_read_allowed, combinational; else both 0.
REQ-024 Address/data SHALL pass through combinationally; never both mem_write_req and mem_read_req high.
REQ-025 IDLE: cap_write_req -> WRITE (write wins tie); else rb_read_req -> READ; else stay.
REQ-026 WRITE -> DRAIN_W when rb_read_req && (!cap_write_req || wr_cnt == WR_BURST_MAX), or when neither requests.
REQ-027 DRAIN_W: wait for !mem_writes_pending; then -> READ if rb_read_req, else WRITE if cap_write_req, else IDLE.
REQ-028 READ/DRAIN_R mirror REQ-026/027 with rd_cnt, RD_BURST_MAX, mem_reads_pending, write side as the waiter.
REQ-029 wr_cnt/rd_cnt SHALL clear on entry to WRITE/READ, increment per accept, saturate at max.
REQ-030 mem_mode SHALL go 1 on entering READ, 0 on entering WRITE, hold in IDLE/DRAIN states.
REQ-031 Direction never changes while opposite-direction pending is high.
REQ-032 Accept in the cycle WRITE/READ exits still counts; no request lost or duplicated.

Reset
REQ-033 reset: state IDLE, wr_cnt=rd_cnt=0, mem_mode=0, all req/allowed outputs 0 next cycle.
REQ-034 Reset mid-burst SHALL abandon arbitration immediately; in-flight memory-interface transactions are not tracked.

Structure
REQ-035 State encoding and default burst limits SHALL live in the shared dram package.
REQ-036 Single flat module; no sub-module.

Verification
REQ-037 Writes only, 5 accepts, mem_write_allowed=1 -> 5 mem writes, mem_mode=0, returns IDLE after pending drops.
REQ-038 Simultaneous first requests -> WRITE granted first; READ entered only after mem_writes_pending=0.
REQ-039 WR_BURST_MAX=4, continuous writes + read waiting -> exactly 4 write accepts, DRAIN_W, then READ, mem_mode=1.
REQ-040 mem_writes_pending held high 10 cycles in DRAIN_W -> rb_read_allowed stays 0 all 10 cycles.
REQ-041 Reset asserted in READ with rd_cnt=3 -> IDLE, all outputs 0, mem_mode=0 next cycle.
REQ-042 Random req/allowed stress 10k cycles -> accepted count equals mem-side count, no simultaneous mem reqs.

Source files
------------

// File: rtl/dram_req_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dram_req_arbiter_pkg
// Shared definitions for the DRAM request arbiter: the arbitration state
// encoding (also exported on arb_state for debug) and default widths and
// burst limits.
// -----------------------------------------------------------------------------
package dram_req_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF       = 27;
  localparam int unsigned DATA_W_DEF       = 128;
  localparam int unsigned WR_BURST_MAX_DEF = 16;
  localparam int unsigned RD_BURST_MAX_DEF = 8;

  // Encoding is visible on the arb_state debug port, so keep it stable.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_DRAIN_W = 3'd2,
    ST_READ    = 3'd3,
    ST_DRAIN_R = 3'd4
  } arb_state_t;

endpackage

// File: rtl/dram_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// dram_req_arbiter_if
// Bundles the capture (write) side, readback (read) side and memory-interface
// handshake signals of the DRAM request arbiter.
//   slave  : arbiter view (requests/allowed from clients and memory are inputs,
//            forwarded requests and grants are outputs)
//   master : environment view (capture, readback and memory-interface models)
// -----------------------------------------------------------------------------
interface dram_req_arbiter_if
  import dram_req_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  // capture side
  logic              cap_write_req;
  logic [ADDR_W-1:0] cap_wr_adx;
  logic [DATA_W-1:0] cap_wr_data;
  logic              cap_write_allowed;

  // readback side
  logic              rb_read_req;
  logic [ADDR_W-1:0] rb_rd_adx;
  logic              rb_read_allowed;

  // memory interface
  logic              mem_write_req;
  logic [ADDR_W-1:0] mem_wr_adx;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_write_allowed;
  logic              mem_writes_pending;
  logic              mem_read_req;
  logic [ADDR_W-1:0] mem_rd_adx;
  logic              mem_read_allowed;
  logic              mem_reads_pending;

  modport slave (
    input  cap_write_req, cap_wr_adx, cap_wr_data,
    output cap_write_allowed,
    input  rb_read_req, rb_rd_adx,
    output rb_read_allowed,
    output mem_write_req, mem_wr_adx, mem_wr_data,
    input  mem_write_allowed, mem_writes_pending,
    output mem_read_req, mem_rd_adx,
    input  mem_read_allowed, mem_reads_pending
  );

  modport master (
    output cap_write_req, cap_wr_adx, cap_wr_data,
    input  cap_write_allowed,
    output rb_read_req, rb_rd_adx,
    input  rb_read_allowed,
    input  mem_write_req, mem_wr_adx, mem_wr_data,
    output mem_write_allowed, mem_writes_pending,
    input  mem_read_req, mem_rd_adx,
    output mem_read_allowed, mem_reads_pending
  );

endinterface

// File: rtl/dram_req_arbiter.sv
// -----------------------------------------------------------------------------
// dram_req_arbiter
// Arbitrates a capture-side write stream and a readback-side read stream onto
// a single DRAM memory interface. One direction owns the interface at a time;
// the owner is granted by passing its request/allowed handshake straight
// through. When the other side is waiting, the owner is limited to a burst of
// WR_BURST_MAX writes / RD_BURST_MAX reads, after which the arbiter drains the
// memory interface (waits for the pending flag to drop) before turning around.
//
// Ports:
//   clk       : system clock, rising edge
//   reset     : synchronous active-high reset
//   bus       : dram_req_arbiter_if.slave (capture, readback, memory handshakes)
//   mem_mode  : registered direction, 0 = write, 1 = read
//   arb_state : current arbitration state (debug)
// -----------------------------------------------------------------------------
module dram_req_arbiter
  import dram_req_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned WR_BURST_MAX = WR_BURST_MAX_DEF,
  parameter int unsigned RD_BURST_MAX = RD_BURST_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  dram_req_arbiter_if.slave     bus,
  output logic                  mem_mode,
  output logic [2:0]            arb_state
);

  localparam int unsigned WR_CNT_W = $clog2(WR_BURST_MAX + 1);
  localparam int unsigned RD_CNT_W = $clog2(RD_BURST_MAX + 1);
  localparam logic [WR_CNT_W-1:0] WR_CNT_MAX = WR_CNT_W'(WR_BURST_MAX);
  localparam logic [RD_CNT_W-1:0] RD_CNT_MAX = RD_CNT_W'(RD_BURST_MAX);

  arb_state_t          r_state;
  arb_state_t          w_state_next;
  logic [WR_CNT_W-1:0] r_wr_cnt;
  logic [RD_CNT_W-1:0] r_rd_cnt;
  logic [WR_CNT_W-1:0] w_wr_cnt_after;
  logic [RD_CNT_W-1:0] w_rd_cnt_after;
  logic                r_mem_mode;
  logic                w_wr_accept;
  logic                w_rd_accept;
  logic                w_wr_limit;
  logic                w_rd_limit;
  logic [ADDR_W-1:0]   w_wr_adx;
  logic [DATA_W-1:0]   w_wr_data;
  logic [ADDR_W-1:0]   w_rd_adx;

  // Address and data are forwarded unconditionally; only the request and
  // allowed strobes are gated by the arbitration state.
  assign w_wr_adx        = bus.cap_wr_adx;
  assign w_wr_data       = bus.cap_wr_data;
  assign w_rd_adx        = bus.rb_rd_adx;
  assign bus.mem_wr_adx  = w_wr_adx;
  assign bus.mem_wr_data = w_wr_data;
  assign bus.mem_rd_adx  = w_rd_adx;

  // Accepts are derived from the raw client/memory strobes so they do not
  // depend on the gated outputs driven below.
  assign w_wr_accept = (r_state == ST_WRITE) && bus.cap_write_req && bus.mem_write_allowed;
  assign w_rd_accept = (r_state == ST_READ)  && bus.rb_read_req   && bus.mem_read_allowed;

  // Burst count including this cycle's accept. Testing the post-accept value
  // lets the exit happen in the same cycle as the last permitted accept, so
  // a waiting side sees exactly WR_BURST_MAX / RD_BURST_MAX transfers go by.
  assign w_wr_cnt_after = (w_wr_accept && (r_wr_cnt != WR_CNT_MAX)) ? r_wr_cnt + 1'b1 : r_wr_cnt;
  assign w_rd_cnt_after = (w_rd_accept && (r_rd_cnt != RD_CNT_MAX)) ? r_rd_cnt + 1'b1 : r_rd_cnt;
  assign w_wr_limit     = (w_wr_cnt_after == WR_CNT_MAX);
  assign w_rd_limit     = (w_rd_cnt_after == RD_CNT_MAX);

  // Next state and handshake gating.
  always_comb begin
    w_state_next          = r_state;
    bus.mem_write_req     = 1'b0;
    bus.cap_write_allowed = 1'b0;
    bus.mem_read_req      = 1'b0;
    bus.rb_read_allowed   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.cap_write_req) begin
          w_state_next = ST_WRITE;
        end else if (bus.rb_read_req) begin
          w_state_next = ST_READ;
        end
      end

      ST_WRITE: begin
        bus.mem_write_req     = bus.cap_write_req;
        bus.cap_write_allowed = bus.mem_write_allowed;
        if ((bus.rb_read_req && (!bus.cap_write_req || w_wr_limit)) ||
            (!bus.rb_read_req && !bus.cap_write_req)) begin
          w_state_next = ST_DRAIN_W;
        end
      end

      ST_DRAIN_W: begin
        // After a write burst the reader gets priority.
        if (!bus.mem_writes_pending) begin
          if (bus.rb_read_req) begin
            w_state_next = ST_READ;
          end else if (bus.cap_write_req) begin
            w_state_next = ST_WRITE;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end

      ST_READ: begin
        bus.mem_read_req    = bus.rb_read_req;
        bus.rb_read_allowed = bus.mem_read_allowed;
        if ((bus.cap_write_req && (!bus.rb_read_req || w_rd_limit)) ||
            (!bus.cap_write_req && !bus.rb_read_req)) begin
          w_state_next = ST_DRAIN_R;
        end
      end

      ST_DRAIN_R: begin
        // After a read burst the writer gets priority.
        if (!bus.mem_reads_pending) begin
          if (bus.cap_write_req) begin
            w_state_next = ST_WRITE;
          end else if (bus.rb_read_req) begin
            w_state_next = ST_READ;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_mem_mode <= 1'b0;
    end else begin
      r_state <= w_state_next;

      // Counters restart on every entry into their burst state.
      if ((w_state_next == ST_WRITE) && (r_state != ST_WRITE)) begin
        r_wr_cnt <= '0;
      end else if (r_state == ST_WRITE) begin
        r_wr_cnt <= w_wr_cnt_after;
      end

      if ((w_state_next == ST_READ) && (r_state != ST_READ)) begin
        r_rd_cnt <= '0;
      end else if (r_state == ST_READ) begin
        r_rd_cnt <= w_rd_cnt_after;
      end

      // Direction flips only on entry into a burst state; drain states
      // guarantee the opposite side has no pending traffic by then.
      if ((w_state_next == ST_READ) && (r_state != ST_READ)) begin
        r_mem_mode <= 1'b1;
      end else if ((w_state_next == ST_WRITE) && (r_state != ST_WRITE)) begin
        r_mem_mode <= 1'b0;
      end
    end
  end

  assign mem_mode  = r_mem_mode;
  assign arb_state = r_state;

endmodule
